sd_seq_src: RTL
===============

// Module: sd_seq_src
// PURPOSE
//  Synthesizable srdy/drdy stream producer for bench and formal envs: sources a
//  programmed number of words of incrementing data, with LFSR-paced srdy gaps.
//  Drives the c_ side of any sdlib buffer (sd_fifo_c, sd_iofull); a checker on
//  the far p_ side verifies order/count. Also usable on-chip as a BIST source.
// PARAMETERS
//  width   8        data word width
//  cnt_sz  16       width of word-count / sent-count
//  lfsr_init 16'hACE1  LFSR reset value; must be nonzero
// PORTS
//  clk        in   1       clock
//  reset_n    in   1       asynchronous, active-low reset
//  start      in   1       1-cycle request to begin a run; sampled in IDLE only
//  num_words  in   cnt_sz  words to send, sampled with start
//  seed_data  in   width   first data value, sampled with start
//  throttle   in   4       0=never gap; larger=more gaps; sampled every cycle
//  p_srdy     out  1       producer valid
//  p_drdy     in   1       consumer ready
//  p_data     out  width   producer data
//  busy       out  1       1 while in RUN
//  done       out  1       1-cycle pulse when run completes
//  sent_count out  cnt_sz  words transferred in current/last run
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, p_srdy=0, p_data=0, busy=0,
//   done=0, sent_count=0, lfsr=lfsr_init. All outputs registered.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; steps every cycle out of reset.
//   gate = (lfsr[3:0] >= throttle); throttle=0 -> gate always 1.
//  IDLE: p_srdy=0. start & num_words!=0 -> latch num_words, p_data<=seed_data,
//   sent_count<=0, p_srdy<=gate, ->RUN. start & num_words==0 -> sent_count<=0,
//   ->DONE (no srdy ever asserted).
//  RUN (busy=1):
//   - p_srdy=0: p_srdy<=gate (first offer earliest 1 cycle after start).
//   - p_srdy=1 & !p_drdy: hold p_srdy=1 and p_data stable; never withdraw.
//   - p_srdy & p_drdy (transfer): sent_count+=1; p_data<=p_data+1 (mod 2^width,
//     FF->00 wraps). If sent_count+1==num_words: p_srdy<=0, ->DONE;
//     else p_srdy<=gate (throttle=0 & drdy=1 -> one word every cycle).
//   - start ignored in RUN; num_words/seed_data changes ignored until next start.
//  DONE: done=1 for exactly one cycle, p_srdy=0, ->IDLE. sent_count holds until
//   next accepted start.
//  Count arithmetic: cnt_sz bits, no wrap; max run 2^cnt_sz-1 words.
//  reset_n low mid-run: p_srdy drops asynchronously; run aborted, no done pulse.
// TESTING
//  1 seed=8'hFE,num=4,throttle=0,drdy=1 -> p_data FE,FF,00,01 on 4 consecutive
//    cycles from cycle after start; done pulse next cycle; sent_count=4.
//  2 num=3,throttle=0, drdy low 3 cycles during 2nd word -> p_srdy stays 1,
//    p_data held at seed+1 all 3 cycles; total 3 transfers, done once.
//  3 start with num=0 -> done pulses cycle after start; p_srdy never 1;
//    sent_count=0.
//  4 start re-pulsed mid-run with num=9 -> ignored; run ends at original count.
//  5 reset_n low for 1 cycle mid-run (sent_count=2) -> p_srdy=0 immediately, all
//    outputs at reset values, no done; fresh start runs normally.
//  6 throttle=15, random drdy, num=1000 into sd_fifo_c depth 5 with fv_fifo
//    scoreboard -> 1000 in-order words, gaps on p_srdy observed, no mismatch.

Source files
------------

// File: rtl/sd_seq_src.sv
// srdy/drdy stream producer: sends a programmed number of incrementing data
// words, with LFSR-paced gaps on p_srdy. Usable as a bench source or BIST source.
module sd_seq_src #(
   parameter int          width     = 8,
   parameter int          cnt_sz    = 16,
   parameter logic [15:0] lfsr_init = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [cnt_sz-1:0] num_words,
   input  logic [width-1:0]  seed_data,
   input  logic [3:0]        throttle,
   output logic              p_srdy,
   input  logic              p_drdy,
   output logic [width-1:0]  p_data,
   output logic              busy,
   output logic              done,
   output logic [cnt_sz-1:0] sent_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [cnt_sz-1:0] ONE_C = 1;
   localparam logic [width-1:0]  ONE_D = 1;

   state_t              r_state, w_nxt;
   logic [15:0]         r_lfsr;
   logic                r_srdy, w_srdy;
   logic [width-1:0]    r_data, w_data;
   logic [cnt_sz-1:0]   r_cnt, w_cnt;
   logic [cnt_sz-1:0]   r_num, w_num;
   logic                r_busy, r_done;
   logic                w_gate;
   logic                w_fb;

   // Fibonacci LFSR, taps 16,14,13,11; its low nibble paces the srdy offers.
   assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_gate = (r_lfsr[3:0] >= throttle);

   always_comb begin
      w_nxt  = r_state;
      w_srdy = r_srdy;
      w_data = r_data;
      w_cnt  = r_cnt;
      w_num  = r_num;
      case (r_state)
         S_IDLE: begin
            w_srdy = 1'b0;
            if (start) begin
               w_cnt = '0;
               if (num_words != '0) begin
                  w_num  = num_words;
                  w_data = seed_data;
                  w_srdy = w_gate;
                  w_nxt  = S_RUN;
               end else begin
                  w_nxt = S_DONE;
               end
            end
         end
         S_RUN: begin
            // An offer, once made, is held until the consumer takes it.
            if (!r_srdy) begin
               w_srdy = w_gate;
            end else if (p_drdy) begin
               w_cnt  = r_cnt + ONE_C;
               w_data = r_data + ONE_D;
               if (w_cnt == r_num) begin
                  w_srdy = 1'b0;
                  w_nxt  = S_DONE;
               end else begin
                  w_srdy = w_gate;
               end
            end
         end
         S_DONE: begin
            w_srdy = 1'b0;
            w_nxt  = S_IDLE;
         end
         default: begin
            w_srdy = 1'b0;
            w_nxt  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_lfsr  <= lfsr_init;
         r_srdy  <= 1'b0;
         r_data  <= '0;
         r_cnt   <= '0;
         r_num   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_lfsr  <= {r_lfsr[14:0], w_fb};
         r_srdy  <= w_srdy;
         r_data  <= w_data;
         r_cnt   <= w_cnt;
         r_num   <= w_num;
         r_busy  <= (w_nxt == S_RUN);
         r_done  <= (w_nxt == S_DONE);
      end
   end

   assign p_srdy     = r_srdy;
   assign p_data     = r_data;
   assign busy       = r_busy;
   assign done       = r_done;
   assign sent_count = r_cnt;

endmodule
